// File: rtl/mb_load_sched_pkg.sv
// Shared definitions for the macroblock load scheduler: FSM state encoding and
// default counter widths.
package mb_load_sched_pkg;

  localparam int DEF_MB_W_BITS = 8;
  localparam int DEF_MB_H_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/mb_load_sched_raster_cnt.sv
// Raster-order macroblock position counter: x wraps at width-1 and bumps y.
// o_last flags the bottom-right MB of the configured frame.
module mb_raster_cnt #(
  parameter int W_BITS = 8,
  parameter int H_BITS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_step,
  input  logic [W_BITS-1:0] i_cfg_w,
  input  logic [H_BITS-1:0] i_cfg_h,
  output logic [W_BITS-1:0] o_x,
  output logic [H_BITS-1:0] o_y,
  output logic              o_last
);

  localparam logic [W_BITS-1:0] ONE_X = W_BITS'(1);
  localparam logic [H_BITS-1:0] ONE_Y = H_BITS'(1);

  logic [W_BITS-1:0] r_x;
  logic [H_BITS-1:0] r_y;
  logic              w_x_end;
  logic              w_y_end;

  assign w_x_end = (r_x == (i_cfg_w - ONE_X));
  assign w_y_end = (r_y == (i_cfg_h - ONE_Y));

  always_ff @(posedge clk) begin
    if (!rst_n || i_clear) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_step) begin
      if (w_x_end) begin
        r_x <= '0;
        r_y <= w_y_end ? '0 : (r_y + ONE_Y);
      end else begin
        r_x <= r_x + ONE_X;
      end
    end
  end

  assign o_x    = r_x;
  assign o_y    = r_y;
  assign o_last = w_x_end && w_y_end;

endmodule

// File: rtl/mb_load_sched.sv
// Raster-order MB scheduler: overlaps loading MB n+1 with encoding MB n, one MB
// buffered ahead at most. Define MB_LOAD_TMO_EN to add the load watchdog (load_tmo_o).
module mb_load_sched
  import mb_load_sched_pkg::*;
#(
  parameter int MB_W_BITS = DEF_MB_W_BITS,
  parameter int MB_H_BITS = DEF_MB_H_BITS
`ifdef MB_LOAD_TMO_EN
  ,
  parameter int TMO_BITS = 12
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [MB_W_BITS-1:0] mb_w_i,
  input  logic [MB_H_BITS-1:0] mb_h_i,
  output logic                 load_start_o,
  input  logic                 load_done_i,
  output logic                 mb_switch_o,
  input  logic                 pipe_done_i,
  output logic [MB_W_BITS-1:0] mb_x_o,
  output logic [MB_H_BITS-1:0] mb_y_o,
  output logic                 busy_o,
  output logic                 frame_done_o
`ifdef MB_LOAD_TMO_EN
  ,
  output logic                 load_tmo_o
`endif
);

  state_t               r_state;
  logic [MB_W_BITS-1:0] r_cfg_w;
  logic [MB_H_BITS-1:0] r_cfg_h;
  logic                 r_ld_pend;
  logic                 r_buf_full;
  logic                 r_pipe_busy;
  logic                 r_loads_left;
  logic                 r_load_start;
  logic                 r_mb_switch;
  logic                 r_busy;
  logic                 r_frame_done;
  logic [MB_W_BITS-1:0] r_mb_x;
  logic [MB_H_BITS-1:0] r_mb_y;

  logic                 w_accept;
  logic                 w_ld_done;
  logic                 w_pipe_done;
  logic                 w_loaded;
  logic                 w_issue;
  logic                 w_switch;
  logic [MB_W_BITS-1:0] w_ld_x;
  logic [MB_H_BITS-1:0] w_ld_y;
  logic                 w_ld_last;
  logic [MB_W_BITS-1:0] w_sw_x;
  logic [MB_H_BITS-1:0] w_sw_y;
  logic                 w_sw_last;
  logic                 w_unused;

  assign w_accept    = (r_state == ST_IDLE) && start_i && (mb_w_i != '0) && (mb_h_i != '0);
  assign w_ld_done   = load_done_i && r_ld_pend;
  assign w_pipe_done = pipe_done_i && r_pipe_busy;
  // A load finishing this cycle can be switched straight away, without a buffered bubble.
  assign w_loaded    = r_buf_full || w_ld_done;
  assign w_issue     = (r_state == ST_RUN) && !r_ld_pend && !r_buf_full && r_loads_left && !r_load_start;
  assign w_switch    = (r_state == ST_RUN) && w_loaded && (!r_pipe_busy || w_pipe_done);

  mb_raster_cnt #(.W_BITS(MB_W_BITS), .H_BITS(MB_H_BITS)) u_ld_pos (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_accept),
    .i_step  (w_issue),
    .i_cfg_w (r_cfg_w),
    .i_cfg_h (r_cfg_h),
    .o_x     (w_ld_x),
    .o_y     (w_ld_y),
    .o_last  (w_ld_last)
  );

  mb_raster_cnt #(.W_BITS(MB_W_BITS), .H_BITS(MB_H_BITS)) u_sw_pos (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_accept),
    .i_step  (w_switch),
    .i_cfg_w (r_cfg_w),
    .i_cfg_h (r_cfg_h),
    .o_x     (w_sw_x),
    .o_y     (w_sw_y),
    .o_last  (w_sw_last)
  );

  // Only the last-MB flag of the load position matters; the loader tracks its own address.
  assign w_unused = ^{w_ld_x, w_ld_y};

`ifdef MB_LOAD_TMO_EN
  localparam logic [TMO_BITS-1:0] TMO_ONE = TMO_BITS'(1);
  localparam logic [TMO_BITS-1:0] TMO_HIT = {TMO_BITS{1'b1}} - TMO_ONE;

  logic [TMO_BITS-1:0] r_tmo_cnt;
  logic                r_load_tmo;
  logic                w_tmo_hit;

  assign w_tmo_hit  = r_ld_pend && !load_done_i && (r_tmo_cnt == TMO_HIT);
  assign load_tmo_o = r_load_tmo;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cfg_w      <= '0;
      r_cfg_h      <= '0;
      r_ld_pend    <= 1'b0;
      r_buf_full   <= 1'b0;
      r_pipe_busy  <= 1'b0;
      r_loads_left <= 1'b0;
      r_load_start <= 1'b0;
      r_mb_switch  <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_mb_x       <= '0;
      r_mb_y       <= '0;
`ifdef MB_LOAD_TMO_EN
      r_tmo_cnt    <= '0;
      r_load_tmo   <= 1'b0;
`endif
    end else begin
      r_load_start <= 1'b0;
      r_mb_switch  <= 1'b0;
      r_frame_done <= 1'b0;

      if (w_issue) begin
        r_load_start <= 1'b1;
        r_ld_pend    <= 1'b1;
        if (w_ld_last) r_loads_left <= 1'b0;
      end
      if (w_ld_done) r_ld_pend <= 1'b0;

      if (w_switch)       r_buf_full <= 1'b0;
      else if (w_ld_done) r_buf_full <= 1'b1;

      if (w_switch)         r_pipe_busy <= 1'b1;
      else if (w_pipe_done) r_pipe_busy <= 1'b0;

      if (w_switch) begin
        r_mb_switch <= 1'b1;
        r_mb_x      <= w_sw_x;
        r_mb_y      <= w_sw_y;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state      <= ST_RUN;
            r_busy       <= 1'b1;
            r_cfg_w      <= mb_w_i;
            r_cfg_h      <= mb_h_i;
            r_ld_pend    <= 1'b0;
            r_buf_full   <= 1'b0;
            r_pipe_busy  <= 1'b0;
            r_loads_left <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_switch && w_sw_last) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (w_pipe_done) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

`ifdef MB_LOAD_TMO_EN
      // Watchdog abort: the frame is dropped without frame_done.
      r_load_tmo <= 1'b0;
      if (!r_ld_pend || w_ld_done) r_tmo_cnt <= '0;
      else                         r_tmo_cnt <= r_tmo_cnt + TMO_ONE;
      if (w_tmo_hit) begin
        r_load_tmo   <= 1'b1;
        r_state      <= ST_IDLE;
        r_busy       <= 1'b0;
        r_ld_pend    <= 1'b0;
        r_buf_full   <= 1'b0;
        r_pipe_busy  <= 1'b0;
        r_loads_left <= 1'b0;
        r_tmo_cnt    <= '0;
      end
`endif
    end
  end

  assign load_start_o = r_load_start;
  assign mb_switch_o  = r_mb_switch;
  assign mb_x_o       = r_mb_x;
  assign mb_y_o       = r_mb_y;
  assign busy_o       = r_busy;
  assign frame_done_o = r_frame_done;

endmodule

// File: tb/tb_mb_load_sched.sv
// Self-checking bench for mb_load_sched: loader/pipeline responder models, event
// logs, and a coordinate scoreboard filled at frame start and drained on mb_switch.
module tb_mb_load_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_i = 1'b0;
  logic [7:0] mb_w_i = 8'd0;
  logic [7:0] mb_h_i = 8'd0;
  logic       load_start_o;
  logic       load_done_i;
  logic       mb_switch_o;
  logic       pipe_done_i;
  logic [7:0] mb_x_o;
  logic [7:0] mb_y_o;
  logic       busy_o;
  logic       frame_done_o;

  logic respLoadDone = 1'b0;
  logic injLoadDone  = 1'b0;
  logic respPipeDone = 1'b0;
  logic injPipeDone  = 1'b0;

  assign load_done_i = respLoadDone | injLoadDone;
  assign pipe_done_i = respPipeDone | injPipeDone;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int gen = 0;
  int ldLat = 48;
  int pipeLat = 100;
  int startCyc = 0;

  int ldStartQ[$];
  int ldDoneQ[$];
  int switchQ[$];
  int pipeDoneQ[$];
  int frameDoneQ[$];
  logic [15:0] expQ[$];

  mb_load_sched dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .mb_w_i       (mb_w_i),
    .mb_h_i       (mb_h_i),
    .load_start_o (load_start_o),
    .load_done_i  (load_done_i),
    .mb_switch_o  (mb_switch_o),
    .pipe_done_i  (pipe_done_i),
    .mb_x_o       (mb_x_o),
    .mb_y_o       (mb_y_o),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o)
  );

  always #5 clk = ~clk;

  // Inputs change on negedges, so they are logged at posedge with the cycle index.
  always @(posedge clk) begin
    if (load_done_i) ldDoneQ.push_back(cyc);
    if (pipe_done_i) pipeDoneQ.push_back(cyc);
    cyc <= cyc + 1;
  end

  // Output monitor: logs events and drains the coordinate scoreboard on each switch.
  always @(negedge clk) begin
    logic [15:0] expXY;
    if (rst_n) begin
      if (load_start_o) ldStartQ.push_back(cyc);
      if (mb_switch_o) begin
        switchQ.push_back(cyc);
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL switch_unexpected: got switch at (%0d,%0d) expected none", mb_x_o, mb_y_o);
        end else begin
          expXY = expQ.pop_front();
          if ({mb_y_o, mb_x_o} !== expXY) begin
            errors++;
            $display("[TB] FAIL switch_coord: got (%0d,%0d) expected (%0d,%0d)",
                     mb_x_o, mb_y_o, expXY[7:0], expXY[15:8]);
          end
        end
      end
      if (frame_done_o) begin
        frameDoneQ.push_back(cyc);
        checks++;
        if (busy_o !== 1'b0) begin
          errors++;
          $display("[TB] FAIL busy_at_frame_done: got %b expected 0", busy_o);
        end
      end
    end
  end

  // Loader model: load_done ldLat cycles after each load_start.
  always begin : loaderModel
    int g;
    @(negedge clk);
    respLoadDone = 1'b0;
    if (load_start_o) begin
      g = gen;
      repeat (ldLat) @(negedge clk);
      if (g == gen) respLoadDone = 1'b1;
    end
  end

  // Pipeline model: pipe_done pipeLat cycles after each mb_switch.
  always begin : pipeModel
    int g;
    @(negedge clk);
    respPipeDone = 1'b0;
    if (mb_switch_o) begin
      g = gen;
      repeat (pipeLat) @(negedge clk);
      if (g == gen) respPipeDone = 1'b1;
    end
  end

  task automatic clearEvents();
    ldStartQ.delete();
    ldDoneQ.delete();
    switchQ.delete();
    pipeDoneQ.delete();
    frameDoneQ.delete();
  endtask

  // Starts a frame and queues its raster coordinate sequence.
  task automatic applyStimulus(input int w, input int h);
    for (int yy = 0; yy < h; yy++)
      for (int xx = 0; xx < w; xx++)
        expQ.push_back({8'(yy), 8'(xx)});
    @(negedge clk);
    mb_w_i   = 8'(w);
    mb_h_i   = 8'(h);
    start_i  = 1'b1;
    startCyc = cyc;
    @(negedge clk);
    start_i  = 1'b0;
  endtask

  task automatic waitFrame(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (frameDoneQ.size() > 0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({load_start_o, mb_switch_o, busy_o, frame_done_o} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b expected 0000", {load_start_o, mb_switch_o, busy_o, frame_done_o});
    end
    checks++;
    if ({mb_y_o, mb_x_o} !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_coord: got (%0d,%0d) expected (0,0)", mb_x_o, mb_y_o);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({load_start_o, busy_o} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: got %b expected 00", {load_start_o, busy_o});
    end
  endtask

  task automatic test_frame_2x2();
    bit ok;
    ldLat = 48;
    pipeLat = 100;
    clearEvents();
    applyStimulus(2, 2);
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL busy_after_start: got %b expected 1", busy_o);
    end
    waitFrame(2000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL frame2x2_timeout: got no frame_done expected one within 2000 cycles");
    end
    checks++;
    if (ldStartQ.size() != 4 || switchQ.size() != 4 || frameDoneQ.size() != 1) begin
      errors++;
      $display("[TB] FAIL frame2x2_counts: got %0d/%0d/%0d expected 4/4/1",
               ldStartQ.size(), switchQ.size(), frameDoneQ.size());
    end
    checks++;
    if (((ldStartQ.size() > 0) ? ldStartQ[0] : -1) != startCyc + 2) begin
      errors++;
      $display("[TB] FAIL first_load_latency: got cycle %0d expected %0d",
               (ldStartQ.size() > 0) ? ldStartQ[0] : -1, startCyc + 2);
    end
    checks++;
    if (((switchQ.size() > 1) ? switchQ[1] : -1) != ((pipeDoneQ.size() > 0) ? pipeDoneQ[0] + 1 : -2)) begin
      errors++;
      $display("[TB] FAIL pipe_limited_switch: got cycle %0d expected %0d",
               (switchQ.size() > 1) ? switchQ[1] : -1, (pipeDoneQ.size() > 0) ? pipeDoneQ[0] + 1 : -2);
    end
    checks++;
    if (((frameDoneQ.size() > 0) ? frameDoneQ[0] : -1) !=
        ((pipeDoneQ.size() > 0) ? pipeDoneQ[pipeDoneQ.size()-1] + 1 : -2)) begin
      errors++;
      $display("[TB] FAIL frame_done_latency: got cycle %0d expected %0d",
               (frameDoneQ.size() > 0) ? frameDoneQ[0] : -1,
               (pipeDoneQ.size() > 0) ? pipeDoneQ[pipeDoneQ.size()-1] + 1 : -2);
    end
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL busy_after_frame: got %b expected 0", busy_o);
    end
  endtask

  task automatic test_slow_loader();
    bit ok;
    ldLat = 300;
    pipeLat = 10;
    clearEvents();
    applyStimulus(3, 1);
    waitFrame(2000, ok);
    checks++;
    if (!ok || switchQ.size() != 3 || ldStartQ.size() != 3 || ldDoneQ.size() != 3) begin
      errors++;
      $display("[TB] FAIL slow_counts: got ok=%0d %0d/%0d/%0d expected ok=1 3/3/3",
               ok, ldStartQ.size(), ldDoneQ.size(), switchQ.size());
    end
    for (int i = 0; i < switchQ.size() && i < ldDoneQ.size(); i++) begin
      checks++;
      if (switchQ[i] != ldDoneQ[i] + 1) begin
        errors++;
        $display("[TB] FAIL slow_switch_%0d: got cycle %0d expected %0d", i, switchQ[i], ldDoneQ[i] + 1);
      end
    end
    for (int i = 0; i + 1 < ldStartQ.size() && i < switchQ.size(); i++) begin
      checks++;
      if (ldStartQ[i+1] != switchQ[i] + 1) begin
        errors++;
        $display("[TB] FAIL slow_reload_%0d: got cycle %0d expected %0d", i, ldStartQ[i+1], switchQ[i] + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    ldLat = 20;
    pipeLat = 21;
    clearEvents();
    applyStimulus(2, 2);
    waitFrame(2000, ok);
    checks++;
    if (!ok || switchQ.size() != 4 || ldDoneQ.size() != 4 || pipeDoneQ.size() != 4) begin
      errors++;
      $display("[TB] FAIL b2b_counts: got ok=%0d %0d/%0d/%0d expected ok=1 4/4/4",
               ok, ldDoneQ.size(), switchQ.size(), pipeDoneQ.size());
    end
    for (int i = 1; i < switchQ.size() && i < ldDoneQ.size() && i <= pipeDoneQ.size(); i++) begin
      checks++;
      if (pipeDoneQ[i-1] != ldDoneQ[i] || switchQ[i] != ldDoneQ[i] + 1) begin
        errors++;
        $display("[TB] FAIL b2b_switch_%0d: got pipe_done %0d switch %0d expected %0d and %0d",
                 i, pipeDoneQ[i-1], switchQ[i], ldDoneQ[i], ldDoneQ[i] + 1);
      end
    end
  endtask

  task automatic test_spurious();
    bit ok;
    clearEvents();
    @(negedge clk);
    injLoadDone = 1'b1;
    @(negedge clk);
    injLoadDone = 1'b0;
    injPipeDone = 1'b1;
    @(negedge clk);
    injPipeDone = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || ldStartQ.size() != 0 || switchQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL spurious_idle: got busy=%b loads=%0d switches=%0d expected 0/0/0",
               busy_o, ldStartQ.size(), switchQ.size());
    end
    ldLat = 30;
    pipeLat = 30;
    clearEvents();
    applyStimulus(2, 1);
    repeat (3) @(negedge clk);
    injPipeDone = 1'b1;
    @(negedge clk);
    injPipeDone = 1'b0;
    repeat (4) @(negedge clk);
    mb_w_i  = 8'd5;
    mb_h_i  = 8'd5;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    waitFrame(2000, ok);
    checks++;
    if (!ok || ldStartQ.size() != 2 || switchQ.size() != 2 || frameDoneQ.size() != 1) begin
      errors++;
      $display("[TB] FAIL spurious_run_counts: got ok=%0d %0d/%0d/%0d expected ok=1 2/2/1",
               ok, ldStartQ.size(), switchQ.size(), frameDoneQ.size());
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    bit seen;
    ldLat = 10;
    pipeLat = 10;
    clearEvents();
    applyStimulus(2, 2);
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      if (ldStartQ.size() >= 3) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL mid_reset_third_load: got %0d loads expected 3", ldStartQ.size());
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({load_start_o, mb_switch_o, busy_o, frame_done_o, mb_x_o, mb_y_o} !== 20'h0) begin
      errors++;
      $display("[TB] FAIL mid_reset_outputs: got ctrl=%b x=%0d y=%0d expected all 0",
               {load_start_o, mb_switch_o, busy_o, frame_done_o}, mb_x_o, mb_y_o);
    end
    rst_n = 1'b1;
    gen++;
    expQ.delete();
    repeat (20) @(negedge clk);
    clearEvents();
    applyStimulus(1, 1);
    waitFrame(500, ok);
    checks++;
    if (!ok || ldStartQ.size() != 1 || switchQ.size() != 1 || frameDoneQ.size() != 1) begin
      errors++;
      $display("[TB] FAIL frame1x1_counts: got ok=%0d %0d/%0d/%0d expected ok=1 1/1/1",
               ok, ldStartQ.size(), switchQ.size(), frameDoneQ.size());
    end
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL frame1x1_scoreboard: got %0d pending expected 0", expQ.size());
    end
  endtask

  initial begin
    test_reset();
    test_frame_2x2();
    test_slow_loader();
    test_back_to_back();
    test_spurious();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
